// File: rtl/wdog_pkg.sv
// Shared types and helpers for the err_watchdog slice: FSM states, cause codes
// and a saturating counter increment.
package wdog_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    ERROR  = 2'd3
  } wdog_state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_SRC     = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
  localparam logic [1:0] CAUSE_LIMIT   = 2'd3;

  // Operates on a 64-bit container so any counter width up to 64 can share it.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max);
    return (v == max) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/wdog_prio_enc.sv
// Lowest-index-wins priority encoder: returns the index of the first set
// request bit and a flag indicating that any bit was set.
module wdog_prio_enc
  import wdog_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int SW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic [NSRC-1:0] req,
  output logic [SW-1:0]   idx,
  output logic            valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (req[i] && !valid) begin
        idx   = SW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/err_watchdog.sv
// Bench error watchdog: aggregates error sources, detects heartbeat hangs and
// tracks halt. Define WDOG_CYCLE_LIMIT_EN to add the MAX_CYCLES run-length limit.
module err_watchdog
  import wdog_pkg::*;
#(
  parameter int NSRC       = 4,
  parameter int TIMEOUT    = 1000,
  parameter int CW         = 32,
`ifdef WDOG_CYCLE_LIMIT_EN
  parameter int MAX_CYCLES = 100000,
`endif
  parameter int SW         = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            heartbeat,
  input  logic            halt,
  input  logic [NSRC-1:0] err_in,
  output logic            err,
  output logic [1:0]      err_cause,
  output logic [SW-1:0]   err_src,
  output logic            halted,
  output logic [CW-1:0]   cycle_count,
  output logic [CW-1:0]   idle_count
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  wdog_state_t   state;
  logic [SW-1:0] src_idx;
  logic          src_valid;
  logic          timeout_hit;
  logic [CW-1:0] cycle_next;
  logic [CW-1:0] idle_next;

  wdog_prio_enc #(
    .NSRC (NSRC),
    .SW   (SW)
  ) u_prio (
    .req   (err_in),
    .idx   (src_idx),
    .valid (src_valid)
  );

  always_comb begin
    cycle_next  = CW'(sat_inc(64'(cycle_count), 64'(CNT_MAX)));
    idle_next   = heartbeat ? '0 : CW'(sat_inc(64'(idle_count), 64'(CNT_MAX)));
    timeout_hit = (idle_count == CW'(TIMEOUT - 1)) && !heartbeat;
  end

`ifdef WDOG_CYCLE_LIMIT_EN
  logic limit_hit;
  always_comb limit_hit = (cycle_count == CW'(MAX_CYCLES - 1));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      err         <= 1'b0;
      err_cause   <= CAUSE_NONE;
      err_src     <= '0;
      halted      <= 1'b0;
      cycle_count <= '0;
      idle_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cycle_count <= '0;
          idle_count  <= '0;
          if (start) state <= RUN;
        end
        RUN: begin
          // Counters advance in the exit cycle too; they freeze from the next state on.
          cycle_count <= cycle_next;
          idle_count  <= idle_next;
          if (src_valid) begin
            state     <= ERROR;
            err       <= 1'b1;
            err_cause <= CAUSE_SRC;
            err_src   <= src_idx;
          end else if (timeout_hit) begin
            state     <= ERROR;
            err       <= 1'b1;
            err_cause <= CAUSE_TIMEOUT;
          end
`ifdef WDOG_CYCLE_LIMIT_EN
          else if (limit_hit) begin
            state     <= ERROR;
            err       <= 1'b1;
            err_cause <= CAUSE_LIMIT;
          end
`endif
          else if (halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED, ERROR: begin
          state <= state;
        end
      endcase
    end
  end

endmodule
